// File: rtl/fpu_operand_aligner.sv
// fpu_operand_aligner
// Input-side pre-normalization for the FPU add/sub path. Unpacks two IEEE-754
// singles (restoring the hidden bit), orders them by effective exponent, and
// right-shifts the smaller mantissa one bit per cycle with guard/round/sticky
// until both operands share the larger exponent.
module fpu_operand_aligner #(
    parameter int MAX_SHIFT = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_exponent,
    output logic [23:0] out_mant_large,
    output logic [26:0] out_mant_small,
    output logic        out_sign_large,
    output logic        out_sign_small,
    output logic        out_swapped,
    output logic        out_special
);

    localparam int CW = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Operand unpacking: index 0 is operand_a, index 1 is operand_b.
    // A zero exponent field (zero/denormal) has no hidden bit and behaves
    // as exponent 1 so denormals line up with the smallest normals.
    // ------------------------------------------------------------------
    logic [31:0] operand    [2];
    logic [7:0]  eff_exp    [2];
    logic [23:0] unpacked   [2];
    logic        op_sign    [2];
    logic        op_special [2];

    assign operand[0] = operand_a;
    assign operand[1] = operand_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [7:0] exp_field;
            assign exp_field       = operand[gi][30:23];
            assign eff_exp[gi]     = (exp_field == 8'd0) ? 8'd1 : exp_field;
            assign unpacked[gi]    = {(exp_field != 8'd0), operand[gi][22:0]};
            assign op_sign[gi]     = operand[gi][31];
            assign op_special[gi]  = (exp_field == 8'hFF);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Ordering: b is "large" only when strictly bigger, so ties keep a large.
    // ------------------------------------------------------------------
    logic          b_larger;
    logic [7:0]    exp_large;
    logic [7:0]    exp_small;
    logic [7:0]    exp_diff;
    logic [CW-1:0] shift_init;
    logic          any_special;

    assign b_larger    = (eff_exp[1] > eff_exp[0]);
    assign exp_large   = b_larger ? eff_exp[1] : eff_exp[0];
    assign exp_small   = b_larger ? eff_exp[0] : eff_exp[1];
    assign exp_diff    = exp_large - exp_small;
    assign any_special = op_special[0] | op_special[1];
    // Beyond MAX_SHIFT every small-mantissa bit is already folded into sticky.
    assign shift_init  = (int'(exp_diff) > MAX_SHIFT) ? CW'(MAX_SHIFT) : CW'(exp_diff);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [7:0]    exp_reg,        exp_next;
    logic [23:0]   mant_large_reg, mant_large_next;
    logic [26:0]   mant_small_reg, mant_small_next;
    logic          sign_large_reg, sign_large_next;
    logic          sign_small_reg, sign_small_next;
    logic          swapped_reg,    swapped_next;
    logic          special_reg,    special_next;
    logic [CW-1:0] count_reg,      count_next;

    // One alignment step: shift right, OR the bit leaving position 1 into
    // the sticky position so any discarded 1 is remembered.
    logic [26:0] shift_step;
    assign shift_step = {1'b0, mant_small_reg[26:2], mant_small_reg[1] | mant_small_reg[0]};

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_next      = state_reg;
        exp_next        = exp_reg;
        mant_large_next = mant_large_reg;
        mant_small_next = mant_small_reg;
        sign_large_next = sign_large_reg;
        sign_small_next = sign_small_reg;
        swapped_next    = swapped_reg;
        special_next    = special_reg;
        count_next      = count_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    exp_next        = exp_large;
                    swapped_next    = b_larger;
                    special_next    = any_special;
                    mant_large_next = b_larger ? unpacked[1] : unpacked[0];
                    mant_small_next = {(b_larger ? unpacked[0] : unpacked[1]), 3'b000};
                    sign_large_next = b_larger ? op_sign[1] : op_sign[0];
                    sign_small_next = b_larger ? op_sign[0] : op_sign[1];
                    // Specials skip alignment; the mantissas pass through raw.
                    count_next      = any_special ? '0 : shift_init;
                    if (any_special || (shift_init == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_small_next = shift_step;
                count_next      = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; reset clears any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_reg        <= '0;
            mant_large_reg <= '0;
            mant_small_reg <= '0;
            sign_large_reg <= 1'b0;
            sign_small_reg <= 1'b0;
            swapped_reg    <= 1'b0;
            special_reg    <= 1'b0;
            count_reg      <= '0;
        end else begin
            exp_reg        <= exp_next;
            mant_large_reg <= mant_large_next;
            mant_small_reg <= mant_small_next;
            sign_large_reg <= sign_large_next;
            sign_small_reg <= sign_small_next;
            swapped_reg    <= swapped_next;
            special_reg    <= special_next;
            count_reg      <= count_next;
        end
    end

    assign in_ready       = (state_reg == IDLE);
    assign out_valid      = (state_reg == DONE);
    assign out_exponent   = exp_reg;
    assign out_mant_large = mant_large_reg;
    assign out_mant_small = mant_small_reg;
    assign out_sign_large = sign_large_reg;
    assign out_sign_small = sign_small_reg;
    assign out_swapped    = swapped_reg;
    assign out_special    = special_reg;

endmodule

// File: doc/fpu_operand_aligner.md
# fpu_operand_aligner

Input-side pre-normalization stage of the FPU add/sub datapath, the counterpart to the result normalizer. It accepts two IEEE-754 single-precision operands and unpacks them, restoring the hidden bit. It orders them by exponent, then right-shifts the smaller operand's mantissa, one bit per cycle, until both share the larger exponent. The smaller mantissa carries guard, round and sticky bits. Valid/ready handshakes sit on both sides.

## Interface
- `MAX_SHIFT`, default 27: shift-count clamp. The 27-bit small mantissa is fully shifted into sticky at this count.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `operand_a`  in  32  IEEE-754 single.
- `operand_b`  in  32  IEEE-754 single.
- `out_valid`  out  1  aligned result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_exponent`  out  8  common (larger) biased exponent.
- `out_mant_large`  out  24  larger operand: {hidden, fraction}.
- `out_mant_small`  out  27  aligned smaller operand: {hidden, fraction, guard, round, sticky}.
- `out_sign_large`  out  1  sign of the larger operand.
- `out_sign_small`  out  1  sign of the smaller operand.
- `out_swapped`  out  1  1 when operand_b is the larger operand.
- `out_special`  out  1  either operand has exponent 255 (Inf/NaN).

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
- `in_ready` = 1 only in IDLE. `out_valid` = 1 only in DONE.
- **IDLE:** on `in_valid && in_ready`, capture and unpack both operands.
  - Exponent field 0 (zero or denormal): hidden bit 0, effective exponent 1.
  - Otherwise: hidden bit 1, effective exponent equals the field.
- **Ordering:** the larger effective exponent is "large". On a tie, operand_a is large and `out_swapped` = 0.
- **Capture values:**
  - small register = {hidden, fraction, 3'b000}.
  - d = e_large − e_small.
  - count = min(d, MAX_SHIFT).
- **Next state after capture:**
  - `out_special` = 1 → DONE, no shift; mantissas pass through unshifted.
  - count = 0 → DONE.
  - otherwise → SHIFT.
- **SHIFT:** each cycle, m <= {1'b0, m[26:2], m[1]|m[0]} (sticky accumulates) and count decrements. When count reaches 0, go to DONE.
- **DONE:** all outputs held stable while `out_ready` = 0. On `out_ready` = 1, go to IDLE.
- No overlap between transactions; a new input is accepted only in IDLE.
- **Reset values (all asynchronous on `rst_n` low, including mid-SHIFT):**
  - state IDLE, `in_ready` = 1.
  - `out_valid`, `out_exponent`, both mantissas, signs, `out_swapped`, `out_special` = 0.
  - the in-flight transaction is discarded.

## Timing
- Accept at edge N. `out_valid` is high after edge N + count; latency is 1 + min(d, 27) cycles.
- Special operands have latency 1.
- The output handshake completes on an edge with `out_valid && out_ready`. `in_ready` rises in the following cycle.
- Minimum transaction period is 2 + count cycles (IDLE, shifts, DONE).
- `in_valid` arriving in SHIFT/DONE is ignored until IDLE. The upstream must hold its operands.

## Test plan
- **Equal exponents.** Stimulus: a = b = 0x3F800000. Required response: latency 1, `out_exponent` = 127, `out_mant_large` = 0x800000, `out_mant_small` = 0x4000000, `out_swapped` = 0.
- **Swap, d = 1.** Stimulus: a = 0x3F800000, b = 0x40000000. Required response: latency 2, `out_swapped` = 1, `out_exponent` = 128, `out_mant_small` = 0x2000000, sticky 0.
- **Sticky, d = 23.** Stimulus: a = 0x4B000000, b = 0x3F800001. Required response: latency 24, `out_exponent` = 150, `out_mant_small` = 0x0000009.
- **Clamp and denormal-side exponent.** Stimulus: a = 0x7F000000, b = 0x00800000 (d = 253). Required response: latency 28, `out_mant_small` = 0x0000001. Also a = 0x00000001, b = 0x00000000: d = 0, `out_mant_large` = 0x000001, `out_exponent` = 1.
- **Special.** Stimulus: a = 0x7F800000, b = 0x3F800000. Required response: latency 1, `out_special` = 1, mantissas unshifted.
- **Backpressure and reset.** Stimulus: hold `out_ready` = 0 for 10 cycles. Required response: outputs stable, `in_ready` = 0, pulsing `in_valid` has no effect. Then drop `rst_n` mid-SHIFT: all outputs go 0 immediately and `in_ready` = 1. After release, the next transaction completes correctly.
